// File: rtl/id_inst_queue_pkg.sv
// Pipeline-wide types shared by fetch/decode: NOP encoding, fetch exception
// codes and the instruction-queue entry layout.
package id_inst_queue_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        EXC_NONE        = 2'b00,
        EXC_FETCH_FAULT = 2'b01,
        EXC_ADDR_ERR    = 2'b10
    } fetch_exc_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        fetch_exc_e  exc;
    } iq_entry_t;

    localparam int ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: DEPTH entries, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module inst_queue_mem
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/id_inst_queue.sv
// Fetch-to-decode decoupling queue with show-ahead head, NOP bubble when
// empty, and a synchronous whole-queue flush for redirects.
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_inst,
    input  logic [31:0]   in_pc,
    input  logic [1:0]    in_exc,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_pc,
    output logic [1:0]    out_exc,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        empty, full, push, pop;
    iq_entry_t   wr_entry, head;
    logic [ENTRY_W-1:0] head_raw;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & ~full;
    assign pop       = ~empty & out_ready;

    assign wr_entry.pc   = in_pc;
    assign wr_entry.inst = in_inst;
    assign wr_entry.exc  = fetch_exc_e'(in_exc);

    inst_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .we_i    (push & ~flush),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (head_raw)
    );

    assign head     = iq_entry_t'(head_raw);
    assign out_inst = empty ? NOP_INST : head.inst;
    assign out_pc   = empty ? 32'h0    : head.pc;
    assign out_exc  = empty ? EXC_NONE : head.exc;
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + PTR_ONE;
            else if (pop && !push) count_d = count_q - PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed, table-driven bench for id_inst_queue plus hand-written sequences
// for sustained throughput, wrap-around and asynchronous reset.
module tb_id_inst_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [1:0]  in_exc = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  out_exc;
    logic        out_ready = 1'b0;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    id_inst_queue #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_exc    (in_exc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_exc   (out_exc),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        fl, iv, ordy;
        logic [31:0] inst, pc;
        logic [1:0]  exc;
        logic        e_valid, e_rdy;
        logic [2:0]  e_cnt;
        logic [31:0] e_pc, e_inst;
        logic [1:0]  e_exc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic e_valid, input logic e_rdy,
                           input logic [2:0] e_cnt, input logic [31:0] e_pc,
                           input logic [31:0] e_inst, input logic [1:0] e_exc);
        chk({name, ".out_valid"}, {31'b0, out_valid}, {31'b0, e_valid});
        chk({name, ".in_ready"},  {31'b0, in_ready},  {31'b0, e_rdy});
        chk({name, ".count"},     {29'b0, count},     {29'b0, e_cnt});
        chk({name, ".out_pc"},    out_pc,             e_pc);
        chk({name, ".out_inst"},  out_inst,           e_inst);
        chk({name, ".out_exc"},   {30'b0, out_exc},   {30'b0, e_exc});
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample #1 later.
    task automatic step(input logic fl, input logic iv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic [1:0] exc, input logic ordy);
        @(negedge clk);
        flush = fl; in_valid = iv; in_inst = inst; in_pc = pc; in_exc = exc; out_ready = ordy;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    function automatic void add(input string name, input logic fl, input logic iv,
                                input logic [31:0] inst, input logic [31:0] pc,
                                input logic [1:0] exc, input logic ordy,
                                input logic e_valid, input logic e_rdy, input logic [2:0] e_cnt,
                                input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic [1:0] e_exc);
        vec_t v;
        v.name = name; v.fl = fl; v.iv = iv; v.inst = inst; v.pc = pc; v.exc = exc;
        v.ordy = ordy; v.e_valid = e_valid; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_exc = e_exc;
        tbl.push_back(v);
    endfunction

    initial begin
        //   name         fl iv inst          pc            exc   ordy  vld rdy cnt pc            inst          exc
        add("push0",      0, 1, 32'h20000000, 32'hbfc00000, 2'b00, 0,   1, 1, 3'd1, 32'hbfc00000, 32'h20000000, 2'b00);
        add("push1",      0, 1, 32'h20000001, 32'hbfc00004, 2'b00, 0,   1, 1, 3'd2, 32'hbfc00000, 32'h20000000, 2'b00);
        add("push2",      0, 1, 32'h20000002, 32'hbfc00008, 2'b00, 0,   1, 1, 3'd3, 32'hbfc00000, 32'h20000000, 2'b00);
        add("push3_full", 0, 1, 32'h20000003, 32'hbfc0000c, 2'b00, 0,   1, 0, 3'd4, 32'hbfc00000, 32'h20000000, 2'b00);
        add("push4_drop", 0, 1, 32'h20000004, 32'hbfc00010, 2'b00, 0,   1, 0, 3'd4, 32'hbfc00000, 32'h20000000, 2'b00);
        add("full_pp",    0, 1, 32'h20000004, 32'hbfc00010, 2'b00, 1,   1, 1, 3'd3, 32'hbfc00004, 32'h20000001, 2'b00);
        add("pop1",       0, 0, 32'h0,        32'h0,        2'b00, 1,   1, 1, 3'd2, 32'hbfc00008, 32'h20000002, 2'b00);
        add("pop2",       0, 0, 32'h0,        32'h0,        2'b00, 1,   1, 1, 3'd1, 32'hbfc0000c, 32'h20000003, 2'b00);
        add("pop3_empty", 0, 0, 32'h0,        32'h0,        2'b00, 1,   0, 1, 3'd0, 32'h0,        32'h0,        2'b00);
        add("pop_empty",  0, 0, 32'h0,        32'h0,        2'b00, 1,   0, 1, 3'd0, 32'h0,        32'h0,        2'b00);
        add("nobypass",   0, 1, 32'h24020001, 32'hbfc00020, 2'b00, 0,   1, 1, 3'd1, 32'hbfc00020, 32'h24020001, 2'b00);
        add("exc_push",   0, 1, 32'h8c000000, 32'hbfc00003, 2'b10, 1,   1, 1, 3'd1, 32'hbfc00003, 32'h8c000000, 2'b10);
        add("push_a",     0, 1, 32'h00000011, 32'hbfc00024, 2'b01, 0,   1, 1, 3'd2, 32'hbfc00003, 32'h8c000000, 2'b10);
        add("push_b",     0, 1, 32'h00000012, 32'hbfc00028, 2'b00, 0,   1, 1, 3'd3, 32'hbfc00003, 32'h8c000000, 2'b10);
        add("flush_pp",   1, 1, 32'h00000013, 32'hbfc0002c, 2'b00, 1,   0, 1, 3'd0, 32'h0,        32'h0,        2'b00);
        add("flush_hold", 1, 1, 32'h00000013, 32'hbfc0002c, 2'b00, 0,   0, 1, 3'd0, 32'h0,        32'h0,        2'b00);
        add("post_flush", 0, 1, 32'h00000014, 32'hbfc00030, 2'b00, 0,   1, 1, 3'd1, 32'hbfc00030, 32'h00000014, 2'b00);

        // Asynchronous reset before the first edge.
        #1 reset = 1'b1;
        #1 chk_all("reset", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 2'b00);
        #10 reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].inst, tbl[i].pc, tbl[i].exc, tbl[i].ordy);
            chk_all(tbl[i].name, tbl[i].e_valid, tbl[i].e_rdy, tbl[i].e_cnt,
                    tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_exc);
        end

        // Sustained push+pop at count 2; 22 pushes total wraps the 3-bit pointers twice.
        step(1'b1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step(1'b0, 1'b1, 32'hA000_0000, 32'h0000_0100, 2'b00, 1'b0);
        step(1'b0, 1'b1, 32'hA000_0001, 32'h0000_0104, 2'b00, 1'b0);
        chk("stream.prefill_cnt", {29'b0, count}, 32'd2);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("stream.head%0d", k), out_pc, 32'h100 + 32'(4 * k));
            step(1'b0, 1'b1, 32'hA000_0002 + 32'(k), 32'h108 + 32'(4 * k), 2'b00, 1'b1);
            chk($sformatf("stream.cnt%0d", k), {29'b0, count}, 32'd2);
            chk($sformatf("stream.inst%0d", k), out_inst, 32'hA000_0001 + 32'(k));
        end
        chk("stream.tail0", out_pc, 32'h150);
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        chk("stream.tail1", out_pc, 32'h154);
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1);
        chk_all("stream.drained", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 2'b00);

        // Asynchronous reset mid-cycle with two entries queued.
        step(1'b0, 1'b1, 32'hB000_0000, 32'h0000_0200, 2'b00, 1'b0);
        step(1'b0, 1'b1, 32'hB000_0001, 32'h0000_0204, 2'b01, 1'b0);
        chk("areset.pre_cnt", {29'b0, count}, 32'd2);
        #2 reset = 1'b1;
        #1 chk_all("areset", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 2'b00);
        #1 reset = 1'b0;
        step(1'b0, 1'b1, 32'hB000_0002, 32'h0000_0208, 2'b01, 1'b0);
        chk_all("areset.push", 1'b1, 1'b1, 3'd1, 32'h208, 32'hB000_0002, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
